// File: rtl/uart_pkg.sv
// uart_pkg: shared state, parity and stop-bit encodings for the UART transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_mode_t;
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; full/empty derived from the occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= count + CW'(wr) - CW'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with per-frame sampled baud divider,
// parity and stop-bit configuration; queued frames go out with no idle gap.
module uart_tx_fifo import uart_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIV_WIDTH-1:0]              baud_div,
    input  logic [1:0]                        parity_mode,
    input  logic                              stop_bits,
    input  logic                              s_valid,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              s_ready,
    output logic                              tx_serial,
    output logic                              busy,
    output logic                              frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
    tx_state_t state, state_n;
    logic [DIV_WIDTH-1:0] cnt, cfg_div;
    logic [1:0] cfg_par;
    logic cfg_stop, stop_idx, par_bit;
    logic [IW-1:0] bit_idx;
    logic [DATA_WIDTH-1:0] shreg, rdata;
    logic full, empty, pop, tick, has_par, stop_last, tx_n;
    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(s_valid),
        .pop(pop),
        .wdata(s_data),
        .rdata(rdata),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    assign s_ready    = !full;
    assign busy       = state != IDLE;
    assign tick       = cnt == '0;
    assign has_par    = cfg_par == PAR_EVEN || cfg_par == PAR_ODD;
    assign stop_last  = cfg_stop == STOP_1 || (stop_idx && cfg_stop == STOP_2);
    assign frame_done = state == STOP && tick && stop_last;
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE:    if (!empty) begin
                         pop     = 1'b1;
                         state_n = START;
                     end
            START:   if (tick) state_n = DATA;
            DATA:    if (tick && bit_idx == LAST) state_n = has_par ? PARITY : STOP;
            PARITY:  if (tick) state_n = STOP;
            STOP:    if (frame_done) begin
                         pop     = !empty;
                         state_n = empty ? IDLE : START;
                     end
            default: state_n = IDLE;
        endcase
        // shreg[1] is the bit that becomes current once this data tick shifts
        tx_n = state_n == START  ? 1'b0 :
               state_n == DATA   ? ((state == DATA && tick) ? shreg[1] : shreg[0]) :
               state_n == PARITY ? par_bit : 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cfg_div   <= '0;
            cfg_par   <= PAR_NONE;
            cfg_stop  <= STOP_1;
            stop_idx  <= 1'b0;
            par_bit   <= 1'b0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx_serial <= 1'b1;
        end else begin
            state     <= state_n;
            tx_serial <= tx_n;
            cnt       <= pop ? baud_div : tick ? cfg_div : cnt - 1'b1;
            if (pop) begin
                shreg    <= rdata;
                cfg_div  <= baud_div;
                cfg_par  <= parity_mode;
                cfg_stop <= stop_bits;
                par_bit  <= parity_mode == PAR_ODD ? ~^rdata : ^rdata;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
            end else if (state == DATA && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
            end else if (state == STOP && tick) begin
                stop_idx <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; pushes queue expected frames, a monitor checks the line.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] baud_div = '0;
    logic [1:0] parity_mode = '0;
    logic stop_bits = 1'b0;
    logic s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic s_ready, tx_serial, busy, frame_done;
    logic [3:0] fifo_count;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [15:0] bits;
        int n;
        int div;
        bit b2b;
    } frame_t;
    frame_t exp_q[$];

    uart_tx_fifo dut (
        .clk(clk),
        .rst(rst),
        .baud_div(baud_div),
        .parity_mode(parity_mode),
        .stop_bits(stop_bits),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .tx_serial(tx_serial),
        .busy(busy),
        .frame_done(frame_done),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic [1:0] par, input logic st,
                                  input int div, input bit b2b);
        frame_t f;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
        f.n = 9;
        if (par == 2'b01 || par == 2'b10) begin
            f.bits[9] = (par == 2'b10) ? ~^d : ^d;
            f.n = 10;
        end
        f.n += st ? 2 : 1;
        f.div = div;
        f.b2b = b2b;
        return f;
    endfunction

    task automatic cfg(input int div, input logic [1:0] par, input logic st);
        baud_div = 16'(div);
        parity_mode = par;
        stop_bits = st;
    endtask

    task automatic push(input logic [7:0] d, input bit b2b);
        int t = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!s_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) chk("push_timeout", 1, 0);
        @(posedge clk);
        exp_q.push_back(mk(d, parity_mode, stop_bits, int'(baud_div), b2b));
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        frame_t e;
        int idle_n;
        idle_n = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) continue;
            if (tx_serial === 1'b1) begin
                idle_n++;
                chk("idle_busy", busy, 0);
                chk("idle_done", frame_done, 0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_start", tx_serial, 1);
            end else begin
                e = exp_q.pop_front();
                if (e.b2b) chk("gap", idle_n, 0);
                for (int b = 0; b < e.n; b++)
                    for (int c = 0; c <= e.div; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        chk($sformatf("tx_bit%0d", b), tx_serial, e.bits[b]);
                        chk("busy", busy, 1);
                        chk("frame_done", frame_done, (b == e.n - 1 && c == e.div) ? 1 : 0);
                    end
                idle_n = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", tx_serial, 1);
        chk("rst_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        cfg(3, 2'b00, 1'b0);
        push(8'hA5, 0);
        wait_idle();

        cfg(3, 2'b01, 1'b0);
        push(8'h07, 0);
        wait_idle();
        cfg(3, 2'b10, 1'b0);
        push(8'h07, 0);
        wait_idle();

        cfg(1, 2'b01, 1'b1);
        push(8'h55, 0);
        repeat (6) @(posedge clk);
        #1 parity_mode = 2'b10;
        push(8'h55, 1);
        wait_idle();

        cfg(15, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push(8'(i * 17 + 1), i > 0);
            if (i == 8) begin
                chk("full_count", fifo_count, 8);
                chk("full_ready", s_ready, 0);
            end
        end
        wait_idle();

        cfg(0, 2'b00, 1'b0);
        push(8'h3C, 0);
        push(8'hC3, 1);
        wait_idle();

        mon_en = 1'b0;
        cfg(3, 2'b00, 1'b0);
        push(8'h00, 0);
        push(8'hFF, 0);
        exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("mid_data_tx", tx_serial, 0);
        chk("mid_data_count", fifo_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", tx_serial, 1);
        chk("arst_count", fifo_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_tx", tx_serial, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", fifo_count, 0);
        mon_en = 1'b1;

        cfg(2, 2'b01, 1'b0);
        push(8'h81, 0);
        wait_idle();

        chk("leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal baud divider, selectable parity (none/even/odd), 1 or 2 stop bits, and a transmit FIFO behind a valid/ready push interface. The block sits between a bus-side register interface and the serial pin. It replaces the externally ticked, fixed-format transmitter, and it sends FIFO contents back-to-back with no idle gap between frames.

## Interface
- DATA_WIDTH, 8: payload bits per frame, legal range 5..9.
- FIFO_DEPTH, 8: number of FIFO entries, power of two, ≥2.
- DIV_WIDTH, 16: width of the baud divider.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- baud_div  in  DIV_WIDTH  bit period in clocks minus one; 0 gives 1 clk/bit.
- parity_mode  in  2  parity select: 00 none, 01 even, 10 odd, 11 treated as none.
- stop_bits  in  1  stop bit count: 0 selects 1 stop bit, 1 selects 2.
- s_valid  in  1  push request.
- s_data  in  DATA_WIDTH  push data.
- s_ready  out  1  FIFO can accept; equals !full.
- tx_serial  out  1  serial line, idle high; registered.
- busy  out  1  high while a frame is on the line.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Push: an entry is written at a clock edge where s_valid && s_ready. When the FIFO is full, s_ready=0 even if a pop happens in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when the FIFO is non-empty, the block pops the head entry at the next edge, loads the shift register, and samples baud_div, parity_mode and stop_bits into frame-config registers. It then enters START.
- Config inputs are ignored mid-frame. They are re-sampled only at each frame start.
- Each bit period lasts baud_div+1 clocks, counted by a down-counter reloaded at every state or bit change.
- START: tx_serial=0 for one bit period.
- DATA: DATA_WIDTH bits, LSB first. A bit index runs 0..DATA_WIDTH-1.
- PARITY: entered only if the frame's parity is even or odd. The bit is ^data for even and ~^data for odd. With parity none, DATA goes directly to STOP.
- STOP: tx_serial=1 for 1 or 2 bit periods.
- At the end of the last stop period, frame_done=1 for one cycle. The FSM then goes to START if the FIFO is non-empty (popping in the same edge), otherwise to IDLE.
- busy=1 in every state except IDLE.

## Timing
- Reset values: tx_serial=1, busy=0, frame_done=0, fifo_count=0, s_ready=1, state=IDLE; FIFO pointers cleared.
- Latency: data accepted into an empty FIFO at edge k while IDLE → tx_serial low from edge k+1.
- Frame length: (1 + DATA_WIDTH + P + S)·(baud_div+1) clocks, where P∈{0,1} and S∈{1,2}. Back-to-back frames add 0 idle clocks.
- Simultaneous push and pop on a non-full FIFO: both happen and fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count.
- Reset mid-frame: tx_serial returns to 1 asynchronously, the FIFO is flushed, and no frame_done is issued.
- baud_div=0: one clock per bit; all states must still sequence correctly.

## Structure
- Package uart_pkg holds: tx_state_t enum (IDLE, START, DATA, PARITY, STOP), parity_mode_t enum (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10), and the stop-bit select constants.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) holds the storage. The FSM, baud counter and shifter live in uart_tx_fifo.

## Test plan
- Reset → tx_serial=1, s_ready=1, busy=0, fifo_count=0, frame_done=0. Assert rst mid-DATA → tx_serial=1 in the same cycle, fifo_count=0.
- DATA_WIDTH=8, baud_div=3, parity none, 1 stop, push 0xA5 → line carries a start bit 0, then data bits 1,0,1,0,0,1,0,1, then a stop bit 1, each held 4 clocks. The frame is 40 clocks, with one frame_done.
- Parity, push 0x07 → parity bit 1 with parity_mode=01 and 0 with parity_mode=10. Frame is 44 clocks at baud_div=3.
- stop_bits=1, baud_div=1 → line stays high for 4 clocks after the last data bit. Changing parity_mode mid-frame affects only the next frame.
- FIFO_DEPTH=8, baud_div=15, push 10 bytes continuously → s_ready drops once 8 entries are held (allowing for the first pop). Remaining bytes are accepted only as pops free space. All 10 frames go out with no idle gap, and busy stays high until the last frame_done.
- baud_div=0, push 0x3C and 0xC3 back-to-back → bit-exact 1-clock-per-bit frames, 10 clocks each, with no gap between them.
